// File: rtl/ld_st_commit_unit.sv
// Commit-time memory responder: one address/data slot per ROB entry, one d-cache
// access per committing LD/ST at the ROB head, single-cycle data_mem_resp back.
module ld_st_commit_unit #(
  parameter int NUM_ENTRIES = 8,
  parameter int TAG_W       = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   addr_valid,
  input  logic [TAG_W-1:0]       addr_tag,
  input  logic [31:0]            addr,
  input  logic [31:0]            st_data,
  input  logic [2:0]             funct3,
  input  logic [NUM_ENTRIES-1:0] alloc_mask,
  input  logic [TAG_W-1:0]       head_ptr,
  input  logic                   rob_data_read,
  input  logic                   rob_data_write,
  input  logic                   flush_in_prog,
  output logic                   data_mem_resp,
  output logic [31:0]            ld_data,
  output logic [NUM_ENTRIES-1:0] slot_ready,
  output logic                   dmem_read,
  output logic                   dmem_write,
  output logic [31:0]            dmem_address,
  output logic [31:0]            dmem_wdata,
  output logic [3:0]             dmem_mbe,
  input  logic [31:0]            dmem_rdata,
  input  logic                   dmem_resp
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state;
  logic [31:0]      slot_addr [NUM_ENTRIES];
  logic [31:0]      slot_data [NUM_ENTRIES];
  logic [2:0]       slot_f3   [NUM_ENTRIES];
  logic [TAG_W-1:0] flight_tag;
  logic [2:0]       flight_f3;
  logic [1:0]       flight_off;

  logic        start;
  logic        busy;
  logic [31:0] h_addr;
  logic [31:0] h_data;
  logic [2:0]  h_f3;

  assign h_addr = slot_addr[head_ptr];
  assign h_data = slot_data[head_ptr];
  assign h_f3   = slot_f3[head_ptr];
  assign busy   = (state != IDLE);
  assign start  = (rob_data_read | rob_data_write) & slot_ready[head_ptr] & ~flush_in_prog;

  function automatic logic [3:0] store_mbe(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << {off[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(rd >> {off, 3'b000});
    h = off[1] ? rd[31:16] : rd[15:0];
    case (f3[1:0])
      2'b00:   return f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   return f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: return rd;
    endcase
  endfunction

  // NOTE: the payload arrays carry no reset; slot_ready alone says whether a slot is valid.
  always_ff @(posedge clk) begin
    if (addr_valid && alloc_mask[addr_tag]) begin
      slot_addr[addr_tag] <= addr;
      slot_data[addr_tag] <= st_data;
      slot_f3[addr_tag]   <= funct3;
    end
  end

  // Later assignments take priority: deallocation beats capture, and the
  // committing slot is immune to deallocation until its response retires it.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_ready <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (addr_valid && alloc_mask[addr_tag] && addr_tag == TAG_W'(i))
          slot_ready[i] <= 1'b1;
        if (!alloc_mask[i] && !(busy && flight_tag == TAG_W'(i)))
          slot_ready[i] <= 1'b0;
        if (state == RESP && flight_tag == TAG_W'(i))
          slot_ready[i] <= 1'b0;
      end
    end
  end

  // NOTE: every registered output is assigned with <= so all of them update on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      flight_tag    <= '0;
      flight_f3     <= '0;
      flight_off    <= '0;
      data_mem_resp <= 1'b0;
      ld_data       <= '0;
      dmem_read     <= 1'b0;
      dmem_write    <= 1'b0;
      dmem_address  <= '0;
      dmem_wdata    <= '0;
      dmem_mbe      <= '0;
    end else begin
      case (state)
        IDLE: begin
          data_mem_resp <= 1'b0;
          if (start) begin
            state        <= ACCESS;
            flight_tag   <= head_ptr;
            flight_f3    <= h_f3;
            flight_off   <= h_addr[1:0];
            // A simultaneous read+write request is resolved as a write.
            dmem_read    <= ~rob_data_write;
            dmem_write   <= rob_data_write;
            dmem_address <= {h_addr[31:2], 2'b00};
            dmem_mbe     <= rob_data_write ? store_mbe(h_f3, h_addr[1:0]) : 4'b1111;
            dmem_wdata   <= rob_data_write ? store_wdata(h_f3, h_data) : '0;
          end
        end
        ACCESS: begin
          if (dmem_resp) begin
            dmem_read     <= 1'b0;
            dmem_write    <= 1'b0;
            data_mem_resp <= 1'b1;
            ld_data       <= dmem_write ? '0 : load_ext(flight_f3, flight_off, dmem_rdata);
            state         <= RESP;
          end
        end
        RESP: begin
          data_mem_resp <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_no_rd_wr: assert property (@(posedge clk) disable iff (rst)
                               !(rob_data_read && rob_data_write));

endmodule

// File: tb/tb_ld_st_commit_unit.sv
// Self-checking bench for ld_st_commit_unit: directed scenarios plus randomized
// LD/ST commits checked against a transaction-level reference model.
module tb_ld_st_commit_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        addr_valid = 1'b0;
  logic [2:0]  addr_tag = '0;
  logic [31:0] addr = '0;
  logic [31:0] st_data = '0;
  logic [2:0]  funct3 = '0;
  logic [7:0]  alloc_mask = 8'hFF;
  logic [2:0]  head_ptr = '0;
  logic        rob_data_read = 1'b0;
  logic        rob_data_write = 1'b0;
  logic        flush_in_prog = 1'b0;
  logic        data_mem_resp;
  logic [31:0] ld_data;
  logic [7:0]  slot_ready;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_resp = 1'b0;

  ld_st_commit_unit #(.NUM_ENTRIES(8), .TAG_W(3)) dut (
    .clk(clk), .rst(rst),
    .addr_valid(addr_valid), .addr_tag(addr_tag), .addr(addr), .st_data(st_data),
    .funct3(funct3), .alloc_mask(alloc_mask), .head_ptr(head_ptr),
    .rob_data_read(rob_data_read), .rob_data_write(rob_data_write),
    .flush_in_prog(flush_in_prog), .data_mem_resp(data_mem_resp), .ld_data(ld_data),
    .slot_ready(slot_ready), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_address(dmem_address), .dmem_wdata(dmem_wdata), .dmem_mbe(dmem_mbe),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: what each slot holds and whether it is ready.
  logic [7:0]  m_ready = '0;
  logic [31:0] m_addr [8];
  logic [31:0] m_data [8];
  logic [2:0]  m_f3   [8];
  int          cur_tag;
  bit          cur_wr;
  logic [31:0] last_ld;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_mbe(input logic [31:0] a, input logic [2:0] f3);
    case (f3)
      3'd0:    return 32'd1 << (a % 4);
      3'd1:    return 32'd3 << (2 * ((a % 4) / 2));
      default: return 32'd15;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] d, input logic [2:0] f3);
    case (f3)
      3'd0:    return (d & 32'hFF) * 32'h0101_0101;
      3'd1:    return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [2:0] f3,
                                           input logic [31:0] rd);
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: begin
        v = (rd >> (8 * (a % 4))) & 32'hFF;
        if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
      end
      3'd1, 3'd5: begin
        v = (rd >> (16 * ((a % 4) / 2))) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  task automatic capture(input int tag, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f3);
    addr_valid = 1'b1;
    addr_tag   = 3'(tag);
    addr       = a;
    st_data    = d;
    funct3     = f3;
    tick();
    addr_valid = 1'b0;
    if (alloc_mask[tag]) begin
      m_ready[tag] = 1'b1;
      m_addr[tag]  = a;
      m_data[tag]  = d;
      m_f3[tag]    = f3;
    end
    check("capture_ready", 32'(slot_ready), 32'(m_ready));
  endtask

  // Raise the ROB request and wait (bounded) for the d-cache access to appear.
  task automatic start_access(input int tag, input bit wr);
    int cnt;
    cnt = 0;
    cur_tag        = tag;
    cur_wr         = wr;
    head_ptr       = 3'(tag);
    rob_data_read  = !wr;
    rob_data_write = wr;
    for (int k = 0; k < 20; k++) begin
      tick();
      cnt++;
      if (dmem_read || dmem_write) break;
    end
    rob_data_read  = 1'b0;
    rob_data_write = 1'b0;
    check("start_latency", 32'(cnt), 32'd1);
    check("dmem_read", 32'(dmem_read), 32'(!wr));
    check("dmem_write", 32'(dmem_write), 32'(wr));
    check("dmem_address", dmem_address, m_addr[tag] & ~32'h3);
    check("dmem_mbe", 32'(dmem_mbe), wr ? exp_mbe(m_addr[tag], m_f3[tag]) : 32'd15);
    if (wr) check("dmem_wdata", dmem_wdata, exp_wdata(m_data[tag], m_f3[tag]));
  endtask

  // The d-cache answers in the lat-th cycle of the access.
  task automatic finish_access(input logic [31:0] rdata, input int lat);
    for (int j = 1; j < lat; j++) begin
      check("hold_address", dmem_address, m_addr[cur_tag] & ~32'h3);
      check("hold_enable", 32'(dmem_read | dmem_write), 32'd1);
      check("no_early_resp", 32'(data_mem_resp), 32'd0);
      tick();
    end
    dmem_resp  = 1'b1;
    dmem_rdata = rdata;
    tick();
    dmem_resp  = 1'b0;
    dmem_rdata = $urandom;
    last_ld    = ld_data;
    check("resp_pulse", 32'(data_mem_resp), 32'd1);
    check("dmem_released", 32'(dmem_read | dmem_write), 32'd0);
    if (!cur_wr) check("ld_data", ld_data, exp_load(m_addr[cur_tag], m_f3[cur_tag], rdata));
    tick();
    check("resp_single", 32'(data_mem_resp), 32'd0);
    m_ready[cur_tag] = 1'b0;
    check("slot_retired", 32'(slot_ready), 32'(m_ready));
  endtask

  initial begin
    logic [2:0] ld_f3s [5];
    ld_f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    // Reset state
    tick();
    tick();
    check("rst_resp", 32'(data_mem_resp), 32'd0);
    check("rst_rw", 32'({dmem_read, dmem_write}), 32'd0);
    check("rst_mbe", 32'(dmem_mbe), 32'd0);
    check("rst_addr", dmem_address, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_ld", ld_data, 32'd0);
    check("rst_ready", 32'(slot_ready), 32'd0);
    rst = 1'b0;
    tick();

    // Word load round-trip
    capture(2, 32'h1000_0004, 32'h0, 3'b010);
    start_access(2, 1'b0);
    finish_access(32'hDEAD_BEEF, 3);
    check("lw_const", last_ld, 32'hDEAD_BEEF);

    // Byte loads: signed then unsigned from offset 3
    capture(0, 32'h0000_3003, 32'h0, 3'b000);
    start_access(0, 1'b0);
    finish_access(32'h8012_3456, 1);
    check("lb_const", last_ld, 32'hFFFF_FF80);
    capture(0, 32'h0000_3003, 32'h0, 3'b100);
    start_access(0, 1'b0);
    finish_access(32'h8012_3456, 2);
    check("lbu_const", last_ld, 32'h0000_0080);

    // Store halfword at upper half
    capture(5, 32'h0000_2002, 32'h1234_ABCD, 3'b001);
    start_access(5, 1'b1);
    check("sh_addr_const", dmem_address, 32'h0000_2000);
    check("sh_mbe_const", 32'(dmem_mbe), 32'h0000_000C);
    check("sh_wdata_const", dmem_wdata, 32'hABCD_ABCD);
    finish_access(32'h0, 2);

    // Not-ready head: request waits until the slot is captured
    head_ptr      = 3'd6;
    rob_data_read = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("notready_idle", 32'(dmem_read | dmem_write), 32'd0);
    end
    capture(6, 32'h0000_0104, 32'h0, 3'b010);
    check("capture_cycle_idle", 32'(dmem_read | dmem_write), 32'd0);
    start_access(6, 1'b0);
    finish_access(32'h0BAD_F00D, 2);

    // Flush while tag 1 is in ACCESS
    capture(1, 32'h0000_0040, 32'h0, 3'b010);
    capture(3, 32'h0000_0050, 32'h0, 3'b010);
    capture(4, 32'h0000_0060, 32'h0, 3'b010);
    capture(5, 32'h0000_0070, 32'h0, 3'b010);
    start_access(1, 1'b0);
    alloc_mask    = 8'hFF & ~8'h18;
    flush_in_prog = 1'b1;
    tick();
    m_ready[3] = 1'b0;
    m_ready[4] = 1'b0;
    check("flush_ready", 32'(slot_ready), 32'(m_ready));
    check("flush_no_abort", 32'(dmem_read), 32'd1);
    capture(3, 32'h0000_0080, 32'h0, 3'b010);
    finish_access(32'h5555_AAAA, 4);
    head_ptr      = 3'd5;
    rob_data_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush_blocks_start", 32'(dmem_read | dmem_write), 32'd0);
    end
    flush_in_prog = 1'b0;
    alloc_mask    = 8'hFF;
    start_access(5, 1'b0);
    finish_access(32'h1357_9BDF, 1);

    // Randomized commits
    for (int it = 0; it < 40; it++) begin
      int          tag;
      int          extra;
      bit          wr;
      logic [2:0]  f3;
      extra = int'($urandom_range(0, 2));
      for (int e = 0; e < extra; e++)
        capture(int'($urandom_range(0, 7)), $urandom, $urandom, ld_f3s[$urandom_range(0, 4)]);
      tag = int'($urandom_range(0, 7));
      wr  = 1'($urandom_range(0, 1));
      f3  = wr ? 3'($urandom_range(0, 2)) : ld_f3s[$urandom_range(0, 4)];
      capture(tag, $urandom, $urandom, f3);
      start_access(tag, wr);
      finish_access($urandom, int'($urandom_range(1, 4)));
    end

    // Reset in the middle of an access; the late d-cache response is ignored
    capture(7, 32'h0000_0900, 32'h0, 3'b010);
    start_access(7, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_ready = '0;
    check("midrst_rw", 32'({dmem_read, dmem_write}), 32'd0);
    check("midrst_resp", 32'(data_mem_resp), 32'd0);
    check("midrst_ready", 32'(slot_ready), 32'(m_ready));
    check("midrst_addr", dmem_address, 32'd0);
    check("midrst_mbe", 32'(dmem_mbe), 32'd0);
    check("midrst_wdata", dmem_wdata, 32'd0);
    check("midrst_ld", ld_data, 32'd0);
    dmem_resp  = 1'b1;
    dmem_rdata = 32'hFFFF_FFFF;
    tick();
    dmem_resp = 1'b0;
    check("late_resp_ignored", 32'(data_mem_resp), 32'd0);
    tick();
    check("late_resp_ignored2", 32'(data_mem_resp), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
